// File: rtl/layer_stream_loader.sv
// Stream-to-accelerator loader: fills inputs/weights/biases from one framed fp16 stream,
// launches the accelerator, then streams its results out. Optional: LAYER_LOADER_WEIGHT_REUSE_EN.
module layer_stream_loader #(
  parameter int N_IN  = 60,
  parameter int N_OUT = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
  input  logic        s_keep_w,
`endif
  output logic        s_ready,
  output logic [15:0] acc_in [N_IN],
  output logic [15:0] acc_w [N_OUT*N_IN],
  output logic [15:0] acc_b [N_OUT],
  output logic        acc_start,
  input  logic [15:0] acc_out [N_OUT],
  input  logic        acc_done,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        err
);

  localparam int N_W        = N_OUT * N_IN;
  localparam int TOTAL_FULL = N_IN + N_W + N_OUT;
  localparam int TOTAL_KEEP = N_IN + N_OUT;
  localparam int CNT_W      = $clog2(TOTAL_FULL);
  localparam int IN_AW      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int W_AW       = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int B_AW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int K_W        = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   w_kNext;
  logic             r_err;
  logic             w_errNext;

  logic [15:0]      r_accIn [N_IN];
  logic [15:0]      r_accW [N_W];
  logic [15:0]      r_accB [N_OUT];

  logic             w_keep;
  logic             w_accept;
  logic             w_inLoad;
  logic             w_lastWord;
  logic             w_lastK;
  logic             w_secIn;
  logic             w_secW;
  logic [CNT_W-1:0] w_lastIdx;
  logic [IN_AW-1:0] w_inIdx;
  logic [W_AW-1:0]  w_wIdx;
  logic [B_AW-1:0]  w_bIdx;

`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
  logic r_keepW;

  // The first word of a frame decides its layout, so use the live flag until it is latched.
  assign w_keep = (r_state == S_IDLE) ? s_keep_w : r_keepW;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_keepW <= 1'b0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_keepW <= s_keep_w;
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  assign w_inLoad   = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign s_ready    = !rst && (w_inLoad || (r_state == S_FLUSH));
  assign w_accept   = s_valid && s_ready;
  assign w_lastIdx  = w_keep ? CNT_W'(TOTAL_KEEP - 1) : CNT_W'(TOTAL_FULL - 1);
  assign w_lastWord = (r_cnt == w_lastIdx);
  assign w_lastK    = (r_k == K_W'(N_OUT - 1));

  // Section decode: inputs, then weights (absent when reusing), then biases.
  assign w_secIn = (r_cnt < CNT_W'(N_IN));
  assign w_secW  = !w_keep && (r_cnt < CNT_W'(N_IN + N_W));
  assign w_inIdx = IN_AW'(r_cnt);
  assign w_wIdx  = W_AW'(r_cnt - CNT_W'(N_IN));
  assign w_bIdx  = w_keep ? B_AW'(r_cnt - CNT_W'(N_IN))
                          : B_AW'(r_cnt - CNT_W'(N_IN + N_W));

  always_ff @(posedge clk) begin
    if (w_accept && w_inLoad) begin
      if (w_secIn) begin
        r_accIn[w_inIdx] <= s_data;
      end else if (w_secW) begin
        r_accW[w_wIdx] <= s_data;
      end else begin
        r_accB[w_bIdx] <= s_data;
      end
    end
  end

  assign acc_in = r_accIn;
  assign acc_w  = r_accW;
  assign acc_b  = r_accB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_k     <= w_kNext;
      r_err   <= w_errNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_kNext     = r_k;
    w_errNext   = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (w_lastWord) begin
            w_cntNext = '0;
            if (s_last) begin
              w_stateNext = S_LAUNCH;
            end else begin
              w_errNext   = 1'b1;
              w_stateNext = S_FLUSH;
            end
          end else if (s_last) begin
            w_cntNext   = '0;
            w_errNext   = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_cntNext   = r_cnt + 1'b1;
            w_stateNext = S_LOAD;
          end
        end
      end
      S_FLUSH: begin
        if (w_accept && s_last) begin
          w_stateNext = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done) begin
          w_kNext     = '0;
          w_stateNext = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (m_ready) begin
          if (w_lastK) begin
            w_kNext     = '0;
            w_stateNext = S_IDLE;
          end else begin
            w_kNext = r_k + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Control outputs read as their reset values for as long as rst is held.
  assign acc_start = !rst && (r_state == S_LAUNCH);
  assign m_valid   = !rst && (r_state == S_DRAIN);
  assign m_last    = m_valid && w_lastK;
  assign m_data    = acc_out[r_k];
  assign busy      = !rst && (r_state != S_IDLE);
  assign err       = !rst && r_err;

endmodule

// File: tb/tb_layer_stream_loader.sv
// Randomized self-checking bench for layer_stream_loader (N_IN=2, N_OUT=2); expected array
// contents and result order come from the frame layout rules, not from the RTL.
module tb_layer_stream_loader;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int N_W   = N_IN * N_OUT;
  localparam int TOTAL = N_IN + N_W + N_OUT;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] acc_in [N_IN];
  logic [15:0] acc_w [N_W];
  logic [15:0] acc_b [N_OUT];
  logic        acc_start;
  logic [15:0] acc_out [N_OUT];
  logic        acc_done;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        err;
`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
  logic        s_keep_w;
`endif

  int          nChecks = 0;
  int          nFails = 0;
  logic [15:0] frameQ[$];
  logic [15:0] expIn [N_IN];
  logic [15:0] expW [N_W];
  logic [15:0] expB [N_OUT];
  logic [15:0] gotData[$];
  logic        gotLast[$];

  layer_stream_loader #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
    .s_keep_w(s_keep_w),
`endif
    .s_ready(s_ready),
    .acc_in(acc_in), .acc_w(acc_w), .acc_b(acc_b), .acc_start(acc_start),
    .acc_out(acc_out), .acc_done(acc_done),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [15:0] d, input logic l);
    int budget = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!s_ready) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL sendWord timeout: s_ready=%b required 1", s_ready);
    end else begin
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic buildFrame(input int n);
    frameQ.delete();
    for (int i = 0; i < n; i++) frameQ.push_back(16'($urandom));
  endtask

  task automatic sendFrame(input int lastAt, input bit gaps);
    for (int i = 0; i < frameQ.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      sendWord(frameQ[i], i == lastAt);
    end
  endtask

  task automatic modelFullFrame();
    for (int i = 0; i < N_IN; i++) expIn[i] = frameQ[i];
    for (int j = 0; j < N_W; j++) expW[j] = frameQ[N_IN + j];
    for (int j = 0; j < N_OUT; j++) expB[j] = frameQ[N_IN + N_W + j];
  endtask

  task automatic randomResults();
    for (int i = 0; i < N_OUT; i++) acc_out[i] = 16'($urandom);
  endtask

  task automatic collectResults(input bit randReady);
    gotData.delete();
    gotLast.delete();
    for (int c = 0; c < 200; c++) begin
      m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        gotData.push_back(m_data);
        gotLast.push_back(m_last);
        if (m_last) begin
          tick();
          m_ready = 1'b0;
          return;
        end
      end
      tick();
    end
    m_ready = 1'b0;
    nChecks++;
    nFails++;
    $display("[TB] FAIL drain timeout: got %0d words required %0d", gotData.size(), N_OUT);
  endtask

  task automatic finishAccel(input bit randReady);
    tick();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    collectResults(randReady);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nChecks++; if (s_ready !== 1'b0)   begin nFails++; $display("[TB] FAIL reset s_ready: got %b required 0", s_ready); end
    nChecks++; if (acc_start !== 1'b0) begin nFails++; $display("[TB] FAIL reset acc_start: got %b required 0", acc_start); end
    nChecks++; if (m_valid !== 1'b0)   begin nFails++; $display("[TB] FAIL reset m_valid: got %b required 0", m_valid); end
    nChecks++; if (m_last !== 1'b0)    begin nFails++; $display("[TB] FAIL reset m_last: got %b required 0", m_last); end
    nChecks++; if (busy !== 1'b0)      begin nFails++; $display("[TB] FAIL reset busy: got %b required 0", busy); end
    nChecks++; if (err !== 1'b0)       begin nFails++; $display("[TB] FAIL reset err: got %b required 0", err); end
    rst = 1'b0;
    tick();
    nChecks++; if (s_ready !== 1'b1) begin nFails++; $display("[TB] FAIL idle s_ready: got %b required 1", s_ready); end
  endtask

  task automatic test_nominal(input int iter);
    buildFrame(TOTAL);
    randomResults();
    sendFrame(TOTAL - 1, iter > 0);
    modelFullFrame();
    nChecks++; if (acc_start !== 1'b1) begin nFails++; $display("[TB] FAIL start pulse: got %b required 1", acc_start); end
    nChecks++; if (s_ready !== 1'b0)   begin nFails++; $display("[TB] FAIL launch s_ready: got %b required 0", s_ready); end
    tick();
    nChecks++; if (acc_start !== 1'b0) begin nFails++; $display("[TB] FAIL start width: got %b required 0", acc_start); end
    nChecks++; if (busy !== 1'b1)      begin nFails++; $display("[TB] FAIL wait busy: got %b required 1", busy); end
    for (int i = 0; i < N_IN; i++) begin
      nChecks++; if (acc_in[i] !== expIn[i]) begin nFails++; $display("[TB] FAIL acc_in[%0d]: got %h required %h", i, acc_in[i], expIn[i]); end
    end
    for (int j = 0; j < N_W; j++) begin
      nChecks++; if (acc_w[j] !== expW[j]) begin nFails++; $display("[TB] FAIL acc_w[%0d]: got %h required %h", j, acc_w[j], expW[j]); end
    end
    for (int j = 0; j < N_OUT; j++) begin
      nChecks++; if (acc_b[j] !== expB[j]) begin nFails++; $display("[TB] FAIL acc_b[%0d]: got %h required %h", j, acc_b[j], expB[j]); end
    end
    tick();
    tick();
    nChecks++; if (m_valid !== 1'b0) begin nFails++; $display("[TB] FAIL m_valid before done: got %b required 0", m_valid); end
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    nChecks++; if (m_valid !== 1'b1) begin nFails++; $display("[TB] FAIL m_valid latency: got %b required 1", m_valid); end
    collectResults(iter > 0);
    nChecks++; if (gotData.size() != N_OUT) begin nFails++; $display("[TB] FAIL result count: got %0d required %0d", gotData.size(), N_OUT); end
    for (int i = 0; i < gotData.size() && i < N_OUT; i++) begin
      nChecks++; if (gotData[i] !== acc_out[i]) begin nFails++; $display("[TB] FAIL m_data[%0d]: got %h required %h", i, gotData[i], acc_out[i]); end
      nChecks++; if (gotLast[i] !== (i == N_OUT - 1)) begin nFails++; $display("[TB] FAIL m_last[%0d]: got %b required %b", i, gotLast[i], i == N_OUT - 1); end
    end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL busy after drain: got %b required 0", busy); end
  endtask

  task automatic test_early_last();
    buildFrame(4);
    sendFrame(3, 1'b0);
    nChecks++; if (err !== 1'b1)       begin nFails++; $display("[TB] FAIL early err: got %b required 1", err); end
    nChecks++; if (busy !== 1'b0)      begin nFails++; $display("[TB] FAIL early busy: got %b required 0", busy); end
    nChecks++; if (acc_start !== 1'b0) begin nFails++; $display("[TB] FAIL early start: got %b required 0", acc_start); end
    tick();
    nChecks++; if (err !== 1'b0)       begin nFails++; $display("[TB] FAIL early err width: got %b required 0", err); end
    nChecks++; if (acc_start !== 1'b0) begin nFails++; $display("[TB] FAIL early no launch: got %b required 0", acc_start); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] badQ[$];
    buildFrame(3);
    badQ = frameQ;
    buildFrame(TOTAL);
    sendWord(badQ[0], 1'b0);
    sendWord(badQ[1], 1'b0);
    sendWord(badQ[2], 1'b1);
    nChecks++; if (err !== 1'b1 || s_ready !== 1'b1) begin nFails++; $display("[TB] FAIL b2b err/ready: got %b/%b required 1/1", err, s_ready); end
    sendFrame(TOTAL - 1, 1'b0);
    modelFullFrame();
    nChecks++; if (acc_start !== 1'b1) begin nFails++; $display("[TB] FAIL b2b launch: got %b required 1", acc_start); end
    for (int i = 0; i < N_IN; i++) begin
      nChecks++; if (acc_in[i] !== expIn[i]) begin nFails++; $display("[TB] FAIL b2b acc_in[%0d]: got %h required %h", i, acc_in[i], expIn[i]); end
    end
    randomResults();
    finishAccel(1'b0);
    nChecks++; if (gotData.size() != N_OUT) begin nFails++; $display("[TB] FAIL b2b result count: got %0d required %0d", gotData.size(), N_OUT); end
  endtask

  task automatic test_missing_last();
    buildFrame(TOTAL);
    sendFrame(-1, 1'b1);
    modelFullFrame();
    nChecks++; if (err !== 1'b1)       begin nFails++; $display("[TB] FAIL nolast err: got %b required 1", err); end
    nChecks++; if (busy !== 1'b1)      begin nFails++; $display("[TB] FAIL flush busy: got %b required 1", busy); end
    nChecks++; if (acc_start !== 1'b0) begin nFails++; $display("[TB] FAIL nolast start: got %b required 0", acc_start); end
    sendWord(16'($urandom), 1'b0);
    nChecks++; if (busy !== 1'b1 || err !== 1'b0) begin nFails++; $display("[TB] FAIL flush extra1 busy/err: got %b/%b required 1/0", busy, err); end
    sendWord(16'($urandom), 1'b1);
    nChecks++; if (busy !== 1'b0)      begin nFails++; $display("[TB] FAIL flush exit busy: got %b required 0", busy); end
    nChecks++; if (acc_start !== 1'b0) begin nFails++; $display("[TB] FAIL flush start: got %b required 0", acc_start); end
    for (int i = 0; i < N_IN; i++) begin
      nChecks++; if (acc_in[i] !== expIn[i]) begin nFails++; $display("[TB] FAIL flush acc_in[%0d]: got %h required %h", i, acc_in[i], expIn[i]); end
    end
    for (int j = 0; j < N_OUT; j++) begin
      nChecks++; if (acc_b[j] !== expB[j]) begin nFails++; $display("[TB] FAIL flush acc_b[%0d]: got %h required %h", j, acc_b[j], expB[j]); end
    end
  endtask

  task automatic test_backpressure();
    buildFrame(TOTAL);
    randomResults();
    sendFrame(TOTAL - 1, 1'b1);
    tick();
    acc_done = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      nChecks++; if (m_valid !== 1'b1 || m_data !== acc_out[0] || m_last !== 1'b0) begin
        nFails++; $display("[TB] FAIL hold cycle %0d: got v=%b d=%h l=%b required v=1 d=%h l=0", c, m_valid, m_data, m_last, acc_out[0]);
      end
      tick();
    end
    collectResults(1'b1);
    acc_done = 1'b0;
    nChecks++; if (gotData.size() != N_OUT) begin nFails++; $display("[TB] FAIL bp result count: got %0d required %0d", gotData.size(), N_OUT); end
    for (int i = 0; i < gotData.size() && i < N_OUT; i++) begin
      nChecks++; if (gotData[i] !== acc_out[i]) begin nFails++; $display("[TB] FAIL bp m_data[%0d]: got %h required %h", i, gotData[i], acc_out[i]); end
    end
  endtask

  task automatic test_reset_wait();
    buildFrame(TOTAL);
    sendFrame(TOTAL - 1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    nChecks++; if (s_ready !== 1'b0 || acc_start !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset in wait: got rdy=%b st=%b mv=%b ml=%b busy=%b err=%b required all 0", s_ready, acc_start, m_valid, m_last, busy, err);
    end
    rst = 1'b0;
    tick();
    nChecks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin nFails++; $display("[TB] FAIL post reset: got busy=%b rdy=%b required 0/1", busy, s_ready); end
    buildFrame(TOTAL);
    randomResults();
    sendFrame(TOTAL - 1, 1'b1);
    modelFullFrame();
    nChecks++; if (acc_start !== 1'b1) begin nFails++; $display("[TB] FAIL post reset launch: got %b required 1", acc_start); end
    for (int j = 0; j < N_W; j++) begin
      nChecks++; if (acc_w[j] !== expW[j]) begin nFails++; $display("[TB] FAIL post reset acc_w[%0d]: got %h required %h", j, acc_w[j], expW[j]); end
    end
    finishAccel(1'b1);
    for (int i = 0; i < gotData.size() && i < N_OUT; i++) begin
      nChecks++; if (gotData[i] !== acc_out[i]) begin nFails++; $display("[TB] FAIL post reset m_data[%0d]: got %h required %h", i, gotData[i], acc_out[i]); end
    end
    nChecks++; if (gotData.size() != N_OUT) begin nFails++; $display("[TB] FAIL post reset count: got %0d required %0d", gotData.size(), N_OUT); end
  endtask

`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
  task automatic test_weight_reuse();
    s_keep_w = 1'b0;
    buildFrame(TOTAL);
    sendFrame(TOTAL - 1, 1'b0);
    modelFullFrame();
    randomResults();
    finishAccel(1'b0);
    buildFrame(N_IN + N_OUT);
    s_keep_w = 1'b1;
    sendFrame(N_IN + N_OUT - 1, 1'b0);
    s_keep_w = 1'b0;
    for (int i = 0; i < N_IN; i++) expIn[i] = frameQ[i];
    for (int j = 0; j < N_OUT; j++) expB[j] = frameQ[N_IN + j];
    nChecks++; if (acc_start !== 1'b1) begin nFails++; $display("[TB] FAIL reuse launch: got %b required 1", acc_start); end
    for (int j = 0; j < N_W; j++) begin
      nChecks++; if (acc_w[j] !== expW[j]) begin nFails++; $display("[TB] FAIL reuse acc_w[%0d]: got %h required %h", j, acc_w[j], expW[j]); end
    end
    for (int j = 0; j < N_OUT; j++) begin
      nChecks++; if (acc_b[j] !== expB[j]) begin nFails++; $display("[TB] FAIL reuse acc_b[%0d]: got %h required %h", j, acc_b[j], expB[j]); end
    end
    for (int i = 0; i < N_IN; i++) begin
      nChecks++; if (acc_in[i] !== expIn[i]) begin nFails++; $display("[TB] FAIL reuse acc_in[%0d]: got %h required %h", i, acc_in[i], expIn[i]); end
    end
    finishAccel(1'b0);
  endtask
`endif

  initial begin
    rst      = 1'b1;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    acc_done = 1'b0;
    m_ready  = 1'b0;
`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
    s_keep_w = 1'b0;
`endif
    for (int i = 0; i < N_OUT; i++) acc_out[i] = '0;
    #2;
    test_reset();
    for (int it = 0; it < 3; it++) test_nominal(it);
    test_early_last();
    test_back_to_back();
    test_missing_last();
    test_backpressure();
    test_reset_wait();
`ifdef LAYER_LOADER_WEIGHT_REUSE_EN
    test_weight_reuse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
